// File: rtl/irs_block_manager.sv
// IRS sample-block allocator: hands out even/odd block pairs to the quad
// write controller, locks trigger history and streams locked pairs out.
module irs_block_manager #(
  parameter int NUM_PAIRS     = 256,
  parameter int PRETRIG_PAIRS = 4,
  localparam int PW = $clog2(NUM_PAIRS),
  localparam int EW = $clog2(PRETRIG_PAIRS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          enable_i,
  input  logic          wr_phase_i,
  input  logic          wr_ack_i,
  output logic [PW:0]   d1_block_o,
  output logic [PW:0]   d2_block_o,
  output logic [PW:0]   d3_block_o,
  output logic [PW:0]   d4_block_o,
  input  logic          trig_i,
  output logic          trig_busy_o,
  output logic [PW-1:0] rd_pair_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  input  logic          free_i,
  input  logic [PW-1:0] free_pair_i,
  output logic          full_o,
  output logic          overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_READY
  } srch_t;

  typedef enum logic {
    E_IDLE,
    E_EMIT
  } emit_t;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] v
  );
    return (v == PW'(NUM_PAIRS - 1)) ?
      '0 : v + PW'(1);
  endfunction

  srch_t s_q, s_d;
  emit_t e_q, e_d;

  logic [PW-1:0]        cur_q;
  logic [PW-1:0]        nxt_q;
  logic                 nv_q;
  logic [PW-1:0]        cand_q;
  logic [PW-1:0]        cnt_q;
  logic [NUM_PAIRS-1:0] lock_q;
  logic [PW-1:0]        hist_q [PRETRIG_PAIRS];
  logic [PRETRIG_PAIRS-1:0] hv_q;
  logic [PW-1:0]        snap_q [PRETRIG_PAIRS+1];
  logic [EW-1:0]        idx_q;
  logic [EW-1:0]        hcnt;

  logic complete, advance, trig_fire, xfer;
  logic cand_ok, cand_ld, found, fail_wrap, drop;

  assign complete  = enable_i & wr_ack_i & ~wr_phase_i;
  assign advance   = complete & nv_q;
  assign trig_fire = enable_i & trig_i & (e_q == E_IDLE);
  assign xfer      = (e_q == E_EMIT) & rd_ready_i;
  assign cand_ok   = ~lock_q[cand_q] & (cand_q != cur_q);

  assign trig_busy_o = (e_q == E_EMIT);
  assign rd_valid_o  = (e_q == E_EMIT);
  assign rd_pair_o   = snap_q[idx_q];

  always_comb begin
    hcnt = '0;
    for (int j = 0; j < PRETRIG_PAIRS; j++)
      hcnt = hcnt + EW'(hv_q[j]);
  end

  always_comb begin
    s_d       = s_q;
    cand_ld   = 1'b0;
    found     = 1'b0;
    fail_wrap = 1'b0;
    drop      = 1'b0;
    unique case (s_q)
      S_IDLE: begin
        if (!nv_q) begin
          s_d     = S_SEARCH;
          cand_ld = 1'b1;
        end
      end
      S_SEARCH: begin
        if (cand_ok) begin
          found = 1'b1;
          s_d   = S_READY;
        end else if (cnt_q == PW'(NUM_PAIRS - 2)) begin
          fail_wrap = 1'b1;
          cand_ld   = 1'b1;
        end
      end
      S_READY: begin
        if (advance) begin
          s_d = S_SEARCH;
        end else if (lock_q[nxt_q]) begin
          drop    = 1'b1;
          s_d     = S_SEARCH;
          cand_ld = 1'b1;
        end
      end
      default: s_d = S_IDLE;
    endcase
  end

  always_comb begin
    e_d = e_q;
    unique case (e_q)
      E_IDLE:  if (trig_fire) e_d = E_EMIT;
      E_EMIT:  if (xfer && idx_q == '0) e_d = E_IDLE;
      default: e_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q <= S_IDLE;
      e_q <= E_IDLE;
    end else begin
      s_q <= s_d;
      e_q <= e_d;
    end
  end

  // allocation datapath
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_q     <= '0;
      nxt_q     <= '0;
      nv_q      <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      full_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= complete & ~nv_q;
      if (cand_ld) begin
        cand_q <= inc(cur_q);
        cnt_q  <= '0;
      end else if (advance) begin
        cand_q <= inc(nxt_q);
        cnt_q  <= '0;
      end else if (s_q == S_SEARCH && !found) begin
        cand_q <= inc(cand_q);
        cnt_q  <= cnt_q + PW'(1);
      end
      if (found) begin
        nxt_q  <= cand_q;
        nv_q   <= 1'b1;
        full_o <= 1'b0;
      end
      if (fail_wrap) full_o <= 1'b1;
      if (drop) nv_q <= 1'b0;
      if (advance) begin
        cur_q <= nxt_q;
        nv_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d1_block_o <= '0;
      d2_block_o <= '0;
      d3_block_o <= '0;
      d4_block_o <= '0;
    end else begin
      d1_block_o <= {cur_q, wr_phase_i};
      d2_block_o <= {cur_q, wr_phase_i};
      d3_block_o <= {cur_q, wr_phase_i};
      d4_block_o <= {cur_q, wr_phase_i};
    end
  end

  // hist[0] is the newest completed pair
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hv_q <= '0;
      for (int j = 0; j < PRETRIG_PAIRS; j++)
        hist_q[j] <= '0;
    end else if (complete) begin
      hist_q[0] <= cur_q;
      hv_q[0]   <= 1'b1;
      for (int j = 1; j < PRETRIG_PAIRS; j++) begin
        hist_q[j] <= hist_q[j-1];
        hv_q[j]   <= hv_q[j-1];
      end
    end
  end

  // set after clear so a coincident trigger keeps the lock
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_q <= '0;
    end else begin
      if (free_i) lock_q[free_pair_i] <= 1'b0;
      if (trig_fire) begin
        lock_q[cur_q] <= 1'b1;
        for (int j = 0; j < PRETRIG_PAIRS; j++)
          if (hv_q[j]) lock_q[hist_q[j]] <= 1'b1;
      end
    end
  end

  // snap[0] = current pair, emitted last
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q <= '0;
      for (int j = 0; j <= PRETRIG_PAIRS; j++)
        snap_q[j] <= '0;
    end else if (trig_fire) begin
      snap_q[0] <= cur_q;
      for (int j = 0; j < PRETRIG_PAIRS; j++)
        snap_q[j+1] <= hist_q[j];
      idx_q <= hcnt;
    end else if (xfer && idx_q != '0) begin
      idx_q <= idx_q - EW'(1);
    end
  end

endmodule
